// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipeline_ctrl_pkg;
  typedef enum logic {RUN, MULDIV} state_t;
  localparam int DEF_MUL_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 33;
  localparam int CNT_W = 6;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs and stall/flush controls between datapath and controller
interface pipeline_hazard_ctrl_if;
  logic imem_busywait, dmem_busywait;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_muldiv_start, ex_is_div;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy, muldiv_done;
  modport master (
    output imem_busywait, dmem_busywait, id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_branch_taken, ex_muldiv_start, ex_is_div,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy, muldiv_done
  );
  modport slave (
    input  imem_busywait, dmem_busywait, id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_branch_taken, ex_muldiv_start, ex_is_div,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy, muldiv_done
  );
endinterface

// File: rtl/muldiv_stall_counter.sv
// muldiv_stall_counter: loadable down-counter with zero detect for multi-cycle EX ops
module muldiv_stall_counter import pipeline_ctrl_pkg::*; (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  always_ff @(posedge CLK)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for the 5-stage pipeline; MULDIV_EN builds the multi-cycle M-extension stall FSM
module pipeline_hazard_ctrl import pipeline_ctrl_pkg::*; #(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input logic CLK,
  input logic reset,
  pipeline_hazard_ctrl_if.slave h
);
  logic bw, go, load_use, md_stall, busy, done, run_br, run_lu;
  assign bw = h.imem_busywait | h.dmem_busywait;
  assign go = ~reset & ~bw;
  assign load_use = h.ex_mem_read & (h.ex_rd != 5'd0) &
    ((h.id_uses_rs1 & (h.id_rs1 == h.ex_rd)) | (h.id_uses_rs2 & (h.id_rs2 == h.ex_rd)));
`ifdef MULDIV_EN
  localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, n_ld;
  logic cnt_zero, start, multi;
  assign multi = h.ex_is_div ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1);
  assign start = (state == RUN) & h.ex_muldiv_start & ~h.ex_branch_taken & multi;
  assign n_ld = (h.ex_is_div ? DIV_N : MUL_N) - CNT_W'(2);
  // cnt counts the MULDIV cycles that remain after the current one
  muldiv_stall_counter u_cnt (
    .CLK(CLK), .reset(reset), .load(start & ~bw), .load_val(n_ld),
    .dec((state == MULDIV) & ~cnt_zero & ~bw), .cnt(cnt), .zero(cnt_zero)
  );
  always_ff @(posedge CLK)
    if (reset) state <= RUN;
    else if (!bw) state <= state_nx;
  always_comb begin
    state_nx = state;
    if (start) state_nx = MULDIV;
    else if (state == MULDIV && cnt_zero) state_nx = RUN;
  end
  assign busy = state == MULDIV;
  assign done = busy & cnt_zero;
  assign md_stall = start | (busy & ~cnt_zero);
`else
  logic unused_md;
  assign unused_md = &{1'b0, CLK, h.ex_muldiv_start, h.ex_is_div, MUL_CYCLES[0], DIV_CYCLES[0]};
  assign busy = 1'b0;
  assign done = 1'b0;
  assign md_stall = 1'b0;
`endif
  assign run_br = ~busy & h.ex_branch_taken;
  assign run_lu = ~busy & ~h.ex_branch_taken & ~md_stall & load_use;
  always_comb begin
    h.pc_en        = go & ~md_stall & ~run_lu;
    h.if_id_en     = go & ~md_stall & ~run_lu;
    h.id_ex_en     = go & ~md_stall;
    h.ex_mem_en    = go;
    h.mem_wb_en    = go;
    h.if_id_flush  = go & run_br;
    h.id_ex_flush  = go & (run_br | run_lu);
    h.ex_mem_flush = go & md_stall;
    h.muldiv_busy  = ~reset & busy;
    h.muldiv_done  = go & done;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the RV32IM 5-stage pipeline. It drives the write-enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves memory busywait, load-use hazards, taken branches/jumps and multi-cycle M-extension operations. It contains one small FSM with a cycle counter; all other outputs are combinational from state and inputs.

## Interface
Parameters:
- MUL_CYCLES, 4: total EX-stage occupancy of MUL/MULH/MULHSU/MULHU (≥1)
- DIV_CYCLES, 33: total EX-stage occupancy of DIV/DIVU/REM/REMU (≥1, ≤63)

Ports:
- CLK  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- imem_busywait  in  1  instruction memory not ready
- dmem_busywait  in  1  data memory not ready
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or a JAL/JALR
- ex_muldiv_start  in  1  EX holds a valid M-extension instruction
- ex_is_div  in  1  qualifies ex_muldiv_start: 1 = div/rem, 0 = mul
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register write enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load a bubble (zeros) instead of the input
- muldiv_busy  out  1  FSM in MULDIV
- muldiv_done  out  1  last EX cycle of a multi-cycle op

## Operation
- States: RUN, MULDIV. Counter cnt is 6 bits.
- Priority order, highest first: reset, busywait, MULDIV, branch, load-use, normal.
- reset: state=RUN, cnt=0. While reset is high, all enables=0, all flushes=0, muldiv_busy=0, muldiv_done=0.
- busywait (imem_busywait | dmem_busywait), in any state:
  - all enables=0, all flushes=0.
  - FSM and cnt hold.
- MULDIV:
  - pc_en=if_id_en=id_ex_en=0; ex_mem_en=1 with ex_mem_flush=1; mem_wb_en=1.
  - cnt decrements each cycle.
  - When cnt==0: all enables=1, no flushes, muldiv_done=1; next state RUN.
- RUN, ex_branch_taken=1:
  - all enables=1, if_id_flush=1, id_ex_flush=1.
  - Overrides a concurrent load-use hazard.
- RUN, load-use hazard (ex_mem_read & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))):
  - pc_en=if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=mem_wb_en=1.
  - Exactly one bubble, because ex_rd no longer matches next cycle.
- RUN, ex_muldiv_start=1 and no busywait:
  - N = ex_is_div ? DIV_CYCLES : MUL_CYCLES.
  - If N>1: cnt←N−2, next state RUN→MULDIV. This cycle: PC/IF/ID/ID-EX hold, EX/MEM bubbles (same outputs as MULDIV).
  - If N==1: no stall.
  - muldiv_start takes priority over the load-use hazard. Branch cannot coincide with muldiv_start; if it does, the branch wins and no MULDIV entry occurs.
- RUN, otherwise: all enables=1, no flushes.
- ex_muldiv_start is ignored while in MULDIV.

## Timing
- Outputs are combinational; they are valid before the CLK edge in the same cycle as the inputs.
- State and cnt are registered on posedge CLK.
- A muldiv op with N cycles holds EX for exactly N non-busywait cycles and inserts N−1 bubbles into EX/MEM.
- Busywait cycles extend the op without being counted.
- Branch penalty: 2 cycles (IF/ID and ID/EX flushed in the same cycle).
- Load-use penalty: 1 cycle.
- Reset asserted mid-MULDIV: RUN at the next edge. The in-flight op is abandoned.

## Configuration
- MULDIV_EN defined: MULDIV state, counter and the muldiv_* logic are built.
- MULDIV_EN undefined:
  - ex_muldiv_start and ex_is_div are ignored; the FSM is fixed in RUN.
  - muldiv_busy=muldiv_done=0; the parameters are unused.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - the state enum (RUN, MULDIV);
  - default MUL_CYCLES/DIV_CYCLES constants;
  - the counter width constant (6).
- One sub-module, muldiv_stall_counter, holds the load/decrement/zero-detect counter. It is instantiated only under MULDIV_EN.

## Test plan
- Reset held 2 cycles during MULDIV → all enables 0 and flushes 0 while reset is high; state=RUN with pc_en=1 on the first cycle after release.
- Load x5 in EX, ID add x6,x5,x7 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; the next cycle all enables=1.
- Load x0 in EX, ID reads x0 → no stall.
- ex_branch_taken=1 together with a load-use match → if_id_flush=id_ex_flush=1, pc_en=1, no stall.
- DIV (DIV_CYCLES=33) → muldiv_busy high for 32 cycles, 32 EX/MEM bubbles, muldiv_done high on cycle 33, then RUN.
- MUL with dmem_busywait high for 3 cycles mid-op → all enables 0 for those 3 cycles; total EX occupancy = 4+3 = 7 cycles.
- Built without MULDIV_EN, ex_muldiv_start=1 → behaves as normal RUN, muldiv_busy stays 0.
